ps2_drive_cmd_ctrl: RTL and testbench
=====================================

PS2_DRIVE_CMD_CTRL -- requirements
Module: ps2_drive_cmd_ctrl

Interface
REQ-001 Parameter KEY_FWD, default 8'h73, is the make code mapped to the forward key.
REQ-002 Parameter KEY_BACK, default 8'h72, is the make code mapped to the backward key.
REQ-003 Parameter KEY_LEFT, default 8'h6B, is the make code mapped to the left key.
REQ-004 Parameter KEY_RIGHT, default 8'h74, is the make code mapped to the right key.
REQ-005 Parameter PREFIX_TIMEOUT, default 50000, is the number of idle cycles after which a pending prefix is discarded.
REQ-006 Parameter WATCHDOG_CYCLES, default 50000000, is the number of idle cycles after which all keys are released (macro-gated).
REQ-007 Port CLOCK_50, input, 1 bit, is the single clock; all logic is on its rising edge.
REQ-008 Port reset, input, 1 bit, is the asynchronous active-high reset.
REQ-009 Port rx_data, input, 8 bits, is the received PS/2 byte.
REQ-010 Port rx_valid, input, 1 bit, is a one-cycle strobe qualifying rx_data.
REQ-011 Port held, output, 4 bits, holds the key states {right,left,back,fwd}; 1 means pressed.
REQ-012 Port accel, output, 2 bits: 2'b10 forward, 2'b01 backward, 2'b00 neutral.
REQ-013 Port steer, output, 2 bits: 2'b10 left, 2'b01 right, 2'b00 straight.
REQ-014 Port key_event, output, 1 bit, is a one-cycle pulse on any change of held.

Function
REQ-015 The decoder FSM SHALL have the states IDLE, GOT_E0, GOT_F0 and GOT_E0F0.
REQ-016 Transitions SHALL occur only on a cycle with rx_valid=1, except timeout and reset.
REQ-017 In IDLE: 8'hE0 goes to GOT_E0; 8'hF0 goes to GOT_F0; a mapped code sets its held bit; any other byte is ignored and the FSM stays in IDLE.
REQ-018 In GOT_E0: 8'hF0 goes to GOT_E0F0; 8'hE0 stays in GOT_E0; a mapped code sets its held bit and returns to IDLE; other bytes return to IDLE.
REQ-019 In GOT_F0 or GOT_E0F0: a mapped code clears its held bit and returns to IDLE; 8'hF0 keeps the state; 8'hE0 goes to GOT_E0; other bytes return to IDLE.
REQ-020 E0-prefixed codes SHALL match the same table, so cursor arrows alias the keypad keys.
REQ-021 8'hE1 and the pause-sequence bytes SHALL be treated as unmapped, with no held change.
REQ-022 A repeated make code (typematic) for an already-held key SHALL leave held unchanged and SHALL NOT pulse key_event.
REQ-023 held, accel, steer and key_event SHALL be registered, valid one cycle after the rx_valid that completes the code.
REQ-024 accel SHALL be 2'b10 if only fwd is held, 2'b01 if only back is held, and 2'b00 if neither or both are held; steer follows the same rule with left/right.
REQ-025 A non-IDLE state SHALL return to IDLE after PREFIX_TIMEOUT consecutive cycles without rx_valid, leaving held unchanged.
REQ-026 The timeout counter SHALL reload on every rx_valid and saturate, never wrap.

Reset
REQ-027 Reset asserted SHALL immediately force IDLE, held=4'b0000, accel=2'b00, steer=2'b00, key_event=0, and clear all counters.
REQ-028 rx_valid during reset SHALL be ignored; a reset mid-sequence (after F0) SHALL discard the prefix.

Configuration
REQ-029 With PS2_DRIVE_WATCHDOG_EN defined, WATCHDOG_CYCLES cycles without rx_valid SHALL clear held, pulse key_event if held was nonzero, and force IDLE.
REQ-030 Without PS2_DRIVE_WATCHDOG_EN, no watchdog logic SHALL exist and held persists indefinitely.

Structure
REQ-031 Package ps2_drive_pkg SHALL hold the FSM state enum, the constants 8'hE0/8'hF0/8'hE1, the default key codes and the accel/steer encodings.
REQ-032 Sub-module ps2_cmd_timer (reloadable saturating down-counter with expiry pulse) SHALL be instantiated for the prefix timeout, and for the watchdog when enabled.

Verification
REQ-033 Byte 73 -> next cycle held=0001, accel=10, key_event pulses once.
REQ-034 Bytes 73, 72 -> accel=00; then F0 73 -> accel=01; then F0 72 -> accel=00, held=0000.
REQ-035 Bytes E0 6B then E0 F0 6B -> steer=10, then 00; bytes E1 14 77 -> no change.
REQ-036 Byte F0, then PREFIX_TIMEOUT idle cycles, then 73 -> fwd set (not released), FSM in IDLE before 73.
REQ-037 Bytes 73 73 73 -> single key_event pulse; reset asserted after F0 then released, then 73 -> held=0001.
REQ-038 With watchdog enabled, byte 74 then WATCHDOG_CYCLES idle cycles -> held=0000, steer=00, one key_event pulse.

Source files
------------

// File: rtl/ps2_drive_pkg.sv
// Shared FSM state, PS/2 prefix bytes, default key map and drive-command encodings.
package ps2_drive_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } state_t;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam logic [7:0] CODE_E1 = 8'hE1;

  localparam logic [7:0] DEF_KEY_FWD   = 8'h73;
  localparam logic [7:0] DEF_KEY_BACK  = 8'h72;
  localparam logic [7:0] DEF_KEY_LEFT  = 8'h6B;
  localparam logic [7:0] DEF_KEY_RIGHT = 8'h74;

  localparam logic [1:0] ACCEL_FWD      = 2'b10;
  localparam logic [1:0] ACCEL_BACK     = 2'b01;
  localparam logic [1:0] ACCEL_NONE     = 2'b00;
  localparam logic [1:0] STEER_LEFT     = 2'b10;
  localparam logic [1:0] STEER_RIGHT    = 2'b01;
  localparam logic [1:0] STEER_STRAIGHT = 2'b00;

  // One-hot {right,left,back,fwd}; prefix and pause bytes never map to a key.
  function automatic logic [3:0] key_mask(input logic [7:0] code, input logic [7:0] k_fwd,
                                          input logic [7:0] k_back, input logic [7:0] k_left,
                                          input logic [7:0] k_right);
    logic [3:0] m;
    m = {code == k_right, code == k_left, code == k_back, code == k_fwd};
    if (code == CODE_E0 || code == CODE_F0 || code == CODE_E1) m = 4'b0000;
    return m;
  endfunction

  function automatic logic [1:0] accel_enc(input logic fwd, input logic back);
    if (fwd && !back) return ACCEL_FWD;
    if (back && !fwd) return ACCEL_BACK;
    return ACCEL_NONE;
  endfunction

  function automatic logic [1:0] steer_enc(input logic left, input logic right);
    if (left && !right) return STEER_LEFT;
    if (right && !left) return STEER_RIGHT;
    return STEER_STRAIGHT;
  endfunction

endpackage

// File: rtl/ps2_cmd_timer.sv
// Reloadable saturating down-counter; o_expire is high on the CYCLES-th consecutive
// cycle without i_reload, then the count rests at zero until the next reload.
module ps2_cmd_timer #(
  parameter int CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_reload,
  output logic o_expire
);

  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LOAD = W'(CYCLES);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_reload) begin
      r_cnt <= LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expire = !i_reload && (r_cnt == W'(1));

endmodule

// File: rtl/ps2_drive_cmd_ctrl.sv
// PS/2 scancode decoder driving held/accel/steer, all registered one cycle after the completing byte.
// Define PS2_DRIVE_WATCHDOG_EN to add an idle watchdog that releases every key.
module ps2_drive_cmd_ctrl
  import ps2_drive_pkg::*;
#(
  parameter logic [7:0] KEY_FWD   = DEF_KEY_FWD,
  parameter logic [7:0] KEY_BACK  = DEF_KEY_BACK,
  parameter logic [7:0] KEY_LEFT  = DEF_KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT = DEF_KEY_RIGHT,
  parameter int PREFIX_TIMEOUT    = 50000,
  parameter int WATCHDOG_CYCLES   = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] held,
  output logic [1:0] accel,
  output logic [1:0] steer,
  output logic       key_event
);

  if (PREFIX_TIMEOUT < 1 || WATCHDOG_CYCLES < 1) begin : g_bad_cfg
    $error("ps2_drive_cmd_ctrl: timer lengths must be at least 1");
  end

  state_t     r_state;
  logic [3:0] r_held;
  logic [1:0] r_accel;
  logic [1:0] r_steer;
  logic       r_key_event;

  logic [3:0] w_mask;
  logic [3:0] w_held_nxt;
  logic       w_prefix_expire;

  assign w_mask = key_mask(rx_data, KEY_FWD, KEY_BACK, KEY_LEFT, KEY_RIGHT);

  // A mapped byte after F0 is a break; otherwise (including E0-prefixed) it is a make.
  always_comb begin
    w_held_nxt = r_held;
    if (rx_valid) begin
      if (r_state == ST_GOT_F0 || r_state == ST_GOT_E0F0) w_held_nxt = r_held & ~w_mask;
      else w_held_nxt = r_held | w_mask;
    end
  end

  ps2_cmd_timer #(
    .CYCLES(PREFIX_TIMEOUT)
  ) u_prefix_timer (
    .i_clk   (CLOCK_50),
    .i_rst   (reset),
    .i_reload(rx_valid),
    .o_expire(w_prefix_expire)
  );

`ifdef PS2_DRIVE_WATCHDOG_EN
  logic w_wdog_expire;

  ps2_cmd_timer #(
    .CYCLES(WATCHDOG_CYCLES)
  ) u_wdog_timer (
    .i_clk   (CLOCK_50),
    .i_rst   (reset),
    .i_reload(rx_valid),
    .o_expire(w_wdog_expire)
  );
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_held      <= 4'b0000;
      r_accel     <= ACCEL_NONE;
      r_steer     <= STEER_STRAIGHT;
      r_key_event <= 1'b0;
    end else begin
      r_key_event <= 1'b0;
`ifdef PS2_DRIVE_WATCHDOG_EN
      if (w_wdog_expire) begin
        r_state     <= ST_IDLE;
        r_held      <= 4'b0000;
        r_accel     <= ACCEL_NONE;
        r_steer     <= STEER_STRAIGHT;
        r_key_event <= |r_held;
      end else
`endif
      begin
        if (rx_valid) begin
          case (r_state)
            ST_IDLE: begin
              if (rx_data == CODE_E0) r_state <= ST_GOT_E0;
              else if (rx_data == CODE_F0) r_state <= ST_GOT_F0;
            end
            ST_GOT_E0: begin
              if (rx_data == CODE_F0) r_state <= ST_GOT_E0F0;
              else if (rx_data != CODE_E0) r_state <= ST_IDLE;
            end
            default: begin
              if (rx_data == CODE_E0) r_state <= ST_GOT_E0;
              else if (rx_data != CODE_F0) r_state <= ST_IDLE;
            end
          endcase
        end else if (w_prefix_expire) begin
          r_state <= ST_IDLE;
        end
        r_held      <= w_held_nxt;
        r_key_event <= (w_held_nxt != r_held);
        r_accel     <= accel_enc(w_held_nxt[0], w_held_nxt[1]);
        r_steer     <= steer_enc(w_held_nxt[2], w_held_nxt[3]);
      end
    end
  end

  assign held      = r_held;
  assign accel     = r_accel;
  assign steer     = r_steer;
  assign key_event = r_key_event;

endmodule

// File: tb/tb_ps2_drive_cmd_ctrl.sv
// Scoreboard bench for ps2_drive_cmd_ctrl; short timer lengths keep the idle scenarios brief.
module tb_ps2_drive_cmd_ctrl;

  localparam int PT = 20;
  localparam int WD = 200;

  typedef struct packed {
    logic [3:0] held;
    logic [1:0] accel;
    logic [1:0] steer;
    logic       ke;
  } out_t;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] held;
  logic [1:0] accel;
  logic [1:0] steer;
  logic       key_event;

  int n_checks = 0;
  int n_fail   = 0;

  out_t exp_q[$];
  out_t obs_q[$];

  logic [3:0] m_held;
  logic       m_e0;
  logic       m_f0;
  int         m_idle;

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_drive_cmd_ctrl #(
    .PREFIX_TIMEOUT (PT),
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .held     (held),
    .accel    (accel),
    .steer    (steer),
    .key_event(key_event)
  );

  function automatic logic [3:0] m_mask(input logic [7:0] b);
    case (b)
      8'h73:   return 4'b0001;
      8'h72:   return 4'b0010;
      8'h6B:   return 4'b0100;
      8'h74:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] m_axis(input logic a, input logic b);
    if (a && !b) return 2'b10;
    if (b && !a) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_held = 4'b0000;
    m_e0   = 1'b0;
    m_f0   = 1'b0;
    m_idle = 0;
  endtask

  // Reference decoder tracks prefixes as two flags rather than a state machine.
  task automatic model_step(input logic v, input logic [7:0] d);
    logic [3:0] old;
    out_t       e;
    old = m_held;
    if (v) begin
      m_idle = 0;
      if (d == 8'hE0) begin
        m_e0 = 1'b1;
        m_f0 = 1'b0;
      end else if (d == 8'hF0) begin
        m_f0 = 1'b1;
      end else begin
        if (m_f0) m_held = m_held & ~m_mask(d);
        else m_held = m_held | m_mask(d);
        m_e0 = 1'b0;
        m_f0 = 1'b0;
      end
    end else begin
      m_idle++;
      if (m_idle == PT) begin
        m_e0 = 1'b0;
        m_f0 = 1'b0;
      end
`ifdef PS2_DRIVE_WATCHDOG_EN
      if (m_idle == WD) begin
        m_held = 4'b0000;
        m_e0   = 1'b0;
        m_f0   = 1'b0;
      end
`endif
    end
    e.held  = m_held;
    e.accel = m_axis(m_held[0], m_held[1]);
    e.steer = m_axis(m_held[2], m_held[3]);
    e.ke    = (old != m_held);
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic v, input logic [7:0] d);
    out_t o;
    @(negedge CLOCK_50);
    rx_valid = v;
    rx_data  = d;
    model_step(v, d);
    @(posedge CLOCK_50);
    #1;
    o = {held, accel, steer, key_event};
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    @(posedge CLOCK_50);
    #1;
    n_checks++;
    if ({held, accel, steer, key_event} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_state: got held=%b accel=%b steer=%b ke=%b, want all zero", held, accel, steer, key_event);
    end
    @(negedge CLOCK_50);
    rx_valid = 1'b1;
    rx_data  = 8'h73;
    @(posedge CLOCK_50);
    #1;
    n_checks++;
    if (held !== 4'b0000 || key_event !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ignores_rx: got held=%b ke=%b, want held=0000 ke=0", held, key_event);
    end
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    reset    = 1'b0;
    model_reset();
  endtask

  task automatic test_fwd_press();
    out_t e, o;
    tick(1'b1, 8'h73);
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL fwd_press[%0d]: got %b/%b/%b/%b want %b/%b/%b/%b", i, o.held, o.accel, o.steer, o.ke, e.held, e.accel, e.steer, e.ke);
      end
    end
  endtask

  task automatic test_accel_mix();
    out_t e, o;
    tick(1'b1, 8'h72);
    tick(1'b1, 8'hF0);
    tick(1'b1, 8'h73);
    tick(1'b0, 8'h00);
    tick(1'b1, 8'hF0);
    tick(1'b1, 8'h72);
    tick(1'b0, 8'h00);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL accel_mix[%0d]: got %b/%b/%b/%b want %b/%b/%b/%b", i, o.held, o.accel, o.steer, o.ke, e.held, e.accel, e.steer, e.ke);
      end
    end
  endtask

  task automatic test_extended();
    out_t e, o;
    logic [7:0] seq [15];
    seq = '{8'hE0, 8'h6B, 8'hE0, 8'hF0, 8'h6B, 8'hE1, 8'h14, 8'h77,
            8'h6B, 8'hE0, 8'h74, 8'hF0, 8'h6B, 8'hF0, 8'h74};
    foreach (seq[k]) tick(1'b1, seq[k]);
    tick(1'b0, 8'h00);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL extended[%0d]: got %b/%b/%b/%b want %b/%b/%b/%b", i, o.held, o.accel, o.steer, o.ke, e.held, e.accel, e.steer, e.ke);
      end
    end
  endtask

  task automatic test_prefix_timeout();
    out_t e, o;
    tick(1'b1, 8'hF0);
    for (int k = 0; k < PT; k++) tick(1'b0, 8'h00);
    tick(1'b1, 8'h73);
    tick(1'b1, 8'hF0);
    tick(1'b1, 8'h73);
    tick(1'b1, 8'hF0);
    for (int k = 0; k < PT - 1; k++) tick(1'b0, 8'h00);
    tick(1'b1, 8'h72);
    tick(1'b0, 8'h00);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL prefix_timeout[%0d]: got %b/%b/%b/%b want %b/%b/%b/%b", i, o.held, o.accel, o.steer, o.ke, e.held, e.accel, e.steer, e.ke);
      end
    end
  endtask

  task automatic test_typematic();
    out_t e, o;
    int pulses;
    pulses = 0;
    tick(1'b1, 8'h73);
    tick(1'b1, 8'h73);
    tick(1'b1, 8'h73);
    tick(1'b0, 8'h00);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o.ke === 1'b1) pulses++;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL typematic[%0d]: got %b/%b/%b/%b want %b/%b/%b/%b", i, o.held, o.accel, o.steer, o.ke, e.held, e.accel, e.steer, e.ke);
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL typematic_pulses: got %0d key_event pulses, want 1", pulses);
    end
  endtask

  task automatic test_reset_mid_sequence();
    out_t e, o;
    tick(1'b1, 8'hF0);
    @(negedge CLOCK_50);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hF0;
    #1;
    n_checks++;
    if ({held, accel, steer, key_event} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_async: got held=%b accel=%b steer=%b ke=%b, want all zero", held, accel, steer, key_event);
    end
    @(negedge CLOCK_50);
    reset    = 1'b0;
    rx_valid = 1'b0;
    model_reset();
    exp_q.delete();
    obs_q.delete();
    tick(1'b1, 8'h73);
    tick(1'b0, 8'h00);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got %b/%b/%b/%b want %b/%b/%b/%b", i, o.held, o.accel, o.steer, o.ke, e.held, e.accel, e.steer, e.ke);
      end
    end
  endtask

  task automatic test_idle_hold();
    out_t e, o;
    int pulses;
    int want_pulses;
    pulses = 0;
`ifdef PS2_DRIVE_WATCHDOG_EN
    want_pulses = 2;
`else
    want_pulses = 1;
`endif
    tick(1'b1, 8'h74);
    for (int k = 0; k < WD + 50; k++) tick(1'b0, 8'h00);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o.ke === 1'b1) pulses++;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: got %b/%b/%b/%b want %b/%b/%b/%b", i, o.held, o.accel, o.steer, o.ke, e.held, e.accel, e.steer, e.ke);
      end
    end
    n_checks++;
    if (pulses !== want_pulses) begin
      n_fail++;
      $display("FAIL idle_hold_pulses: got %0d key_event pulses, want %0d", pulses, want_pulses);
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    test_reset();
    test_fwd_press();
    test_accel_mix();
    test_extended();
    test_prefix_timeout();
    test_typematic();
    test_reset_mid_sequence();
    test_idle_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL tb_time_limit: simulation still running at %0t, want finished", $time);
    $fatal(1, "time limit");
  end

endmodule
